// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button conditioning front end.
//   - state_e: debounce FSM state encoding
//   - DEFAULT_*: cycle counts for the 100 MHz board clock
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // 20 ms of stability before a level change is believed
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 2000000;
  // 1 s of continuous hold counts as a long press
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 100000000;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Reusable two-flop synchronizer for a single asynchronous bit.
// Parameters:
//   RESET_VAL - value both flops take while reset is asserted
// Ports:
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - asynchronous input
//   q_o     - synchronized output (two clocks of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a cycle to settle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Turns a raw bouncing push-button into a debounced level, single-cycle
// press/release/long-press pulses and a run flag for the LED pattern blocks.
// Parameters:
//   DEBOUNCE_CYCLES    - stable cycles needed to accept a level change (>= 2)
//   LONG_PRESS_CYCLES  - cycles held in PRESSED before a long press (> DEBOUNCE)
//   BUTTON_ACTIVE_HIGH - 1: button_i high means pressed, 0: inverted
// Ports:
//   clk_i              - system clock
//   rst_ni             - asynchronous active-low reset
//   button_i           - raw asynchronous button
//   level_o            - debounced pressed state
//   press_pulse_o      - one cycle on an accepted press
//   release_pulse_o    - one cycle on an accepted release
//   long_press_pulse_o - one cycle once per press held long enough
//   run_flag_o         - toggles on each press, cleared by a long press
// -----------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES  = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit          BUTTON_ACTIVE_HIGH = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_press_pulse_o,
  output logic run_flag_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HCNT_ONE  = HW'(1);

  logic          btn_raw;
  logic          btn_s;
  state_e        state_q;
  logic [DW-1:0] dcnt_q;
  logic [HW-1:0] hcnt_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;
  logic          run_q;

  // Normalise polarity before synchronizing so "1" always means pressed
  assign btn_raw = button_i ^ !BUTTON_ACTIVE_HIGH;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (btn_raw),
    .q_o   (btn_s)
  );

  // Debounce FSM, hold timer and all registered outputs. A wait state that
  // sees the old level again drops straight back, which is what filters
  // glitches. The hold timer only advances in PRESSED and is left untouched
  // by a release glitch; it saturates so an endless hold never re-fires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_WAIT;
            dcnt_q  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
          end else if (dcnt_q == DCNT_LAST) begin
            state_q <= PRESSED;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
            run_q   <= ~run_q;
          end else begin
            dcnt_q <= dcnt_q + DCNT_ONE;
          end
        end
        PRESSED: begin
          if (hcnt_q != HCNT_MAX) begin
            hcnt_q <= hcnt_q + HCNT_ONE;
          end
          // hcnt passes this value once per press thanks to saturation
          if (hcnt_q == HCNT_LAST) begin
            long_q <= 1'b1;
            run_q  <= 1'b0;
          end
          if (!btn_s) begin
            state_q <= RELEASE_WAIT;
            dcnt_q  <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state_q <= PRESSED;
            dcnt_q  <= '0;
          end else if (dcnt_q == DCNT_LAST) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + DCNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          dcnt_q  <= '0;
        end
      endcase
    end
  end

  assign level_o            = level_q;
  assign press_pulse_o      = press_q;
  assign release_pulse_o    = release_q;
  assign long_press_pulse_o = long_q;
  assign run_flag_o         = run_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed scenarios plus randomized button activity for button_conditioner,
// checked every cycle against a reference model built on "streak" counting:
// a level change is accepted once the synchronized button has disagreed with
// the accepted level for DEBOUNCE_CYCLES+1 consecutive clock edges.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 16;
  localparam bit ACTIVE_HIGH = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button = 1'b0;
  logic level;
  logic pressPulse;
  logic releasePulse;
  logic longPulse;
  logic runFlag;

  int checkCount = 0;
  int failCount = 0;

  int pressCount = 0;
  int releaseCount = 0;
  int longCount = 0;

  // Reference model state
  bit mLevel = 1'b0;
  bit mPress = 1'b0;
  bit mRelease = 1'b0;
  bit mLong = 1'b0;
  bit mRun = 1'b0;
  int mStreak = 0;
  int mHold = 0;
  bit mS1 = 1'b0;
  bit mS2 = 1'b0;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .BUTTON_ACTIVE_HIGH(ACTIVE_HIGH)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .button_i          (button),
    .level_o           (level),
    .press_pulse_o     (pressPulse),
    .release_pulse_o   (releasePulse),
    .long_press_pulse_o(longPulse),
    .run_flag_o        (runFlag)
  );

  always #5 clk = ~clk;

  // Single point of comparison; every mismatch prints one FAIL line
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive the button from a falling edge and let the given number of cycles pass
  task automatic applyStimulus(input logic value, input int cycles);
    button = value;
    repeat (cycles) @(negedge clk);
  endtask

  // Behavioural model: the FSM sees the button two edges late; disagreement
  // streaks of D+1 edges flip the accepted level. The hold timer advances on
  // edges where the button is accepted-pressed and no release streak is open.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mLevel = 1'b0; mPress = 1'b0; mRelease = 1'b0; mLong = 1'b0; mRun = 1'b0;
      mStreak = 0; mHold = 0; mS1 = 1'b0; mS2 = 1'b0;
    end else begin
      mPress = 1'b0;
      mRelease = 1'b0;
      mLong = 1'b0;
      if (mLevel && mStreak == 0) begin
        if (mHold == L - 1) begin
          mLong = 1'b1;
          mRun = 1'b0;
        end
        if (mHold < L) mHold++;
      end
      if (mS2 != mLevel) mStreak++;
      else mStreak = 0;
      if (mStreak == D + 1) begin
        mStreak = 0;
        mLevel = !mLevel;
        if (mLevel) begin
          mPress = 1'b1;
          mRun = !mRun;
          mHold = 0;
        end else begin
          mRelease = 1'b1;
        end
      end
      mS2 = mS1;
      mS1 = button ^ !ACTIVE_HIGH;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    checkOutput("level", level, mLevel);
    checkOutput("press_pulse", pressPulse, mPress);
    checkOutput("release_pulse", releasePulse, mRelease);
    checkOutput("long_press_pulse", longPulse, mLong);
    checkOutput("run_flag", runFlag, mRun);
  end

  // Pulse tallies for the directed scenarios
  always @(posedge clk) begin
    #1;
    if (pressPulse === 1'b1) pressCount++;
    if (releasePulse === 1'b1) releaseCount++;
    if (longPulse === 1'b1) longCount++;
  end

  task automatic clearCounts();
    pressCount = 0;
    releaseCount = 0;
    longCount = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_level"}, level, 1'b0);
    checkOutput({tag, "_press"}, pressPulse, 1'b0);
    checkOutput({tag, "_release"}, releasePulse, 1'b0);
    checkOutput({tag, "_long"}, longPulse, 1'b0);
    checkOutput({tag, "_run"}, runFlag, 1'b0);
  endtask

  initial begin
    bit bouncePat [6];
    bit v;
    int len;
    bouncePat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 3);

    // Clean press then release
    applyStimulus(1'b1, D + 2);
    checkOutput("clean_press_early", pressPulse, 1'b0);
    applyStimulus(1'b1, 1);
    checkOutput("clean_press", pressPulse, 1'b1);
    checkOutput("clean_level_up", level, 1'b1);
    checkOutput("clean_run_set", runFlag, 1'b1);
    applyStimulus(1'b1, 1);
    checkOutput("clean_press_one_cycle", pressPulse, 1'b0);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, D + 2);
    checkOutput("clean_release_early", releasePulse, 1'b0);
    checkOutput("clean_level_held", level, 1'b1);
    applyStimulus(1'b0, 1);
    checkOutput("clean_release", releasePulse, 1'b1);
    checkOutput("clean_level_down", level, 1'b0);
    applyStimulus(1'b0, 1);
    checkOutput("clean_release_one_cycle", releasePulse, 1'b0);
    applyStimulus(1'b0, 5);

    // Bouncing press
    clearCounts();
    for (int i = 0; i < 5; i++) applyStimulus(bouncePat[i], 1);
    applyStimulus(bouncePat[5], D + 2);
    checkOutput("bounce_no_early_pulse", (pressCount == 0), 1'b1);
    applyStimulus(1'b1, 1);
    checkOutput("bounce_press", pressPulse, 1'b1);
    checkOutput("bounce_run_clear", runFlag, 1'b0);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, D + 8);
    checkOutput("bounce_one_press", (pressCount == 1), 1'b1);
    checkOutput("bounce_one_release", (releaseCount == 1), 1'b1);

    // Long press
    clearCounts();
    applyStimulus(1'b1, D + 3);
    checkOutput("long_press_accept", pressPulse, 1'b1);
    checkOutput("long_run_set", runFlag, 1'b1);
    applyStimulus(1'b1, L - 1);
    checkOutput("long_not_yet", longPulse, 1'b0);
    checkOutput("long_run_before", runFlag, 1'b1);
    applyStimulus(1'b1, 1);
    checkOutput("long_pulse", longPulse, 1'b1);
    checkOutput("long_run_cleared", runFlag, 1'b0);
    applyStimulus(1'b1, 30 - L);
    applyStimulus(1'b0, D + 8);
    checkOutput("long_single_pulse", (longCount == 1), 1'b1);
    checkOutput("long_release_count", (releaseCount == 1), 1'b1);

    // Two short presses
    clearCounts();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, D + 3);
      checkOutput("short_press", pressPulse, 1'b1);
      checkOutput("short_run", runFlag, (i == 0) ? 1'b1 : 1'b0);
      applyStimulus(1'b1, 5);
      applyStimulus(1'b0, D + 8);
    end
    checkOutput("short_press_count", (pressCount == 2), 1'b1);
    checkOutput("short_release_count", (releaseCount == 2), 1'b1);
    checkOutput("short_no_long", (longCount == 0), 1'b1);

    // Two-cycle release glitch while pressed
    clearCounts();
    applyStimulus(1'b1, D + 3);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 30);
    checkOutput("glitch_level_held", level, 1'b1);
    checkOutput("glitch_no_release", (releaseCount == 0), 1'b1);
    checkOutput("glitch_long_once", (longCount == 1), 1'b1);
    applyStimulus(1'b0, D + 8);

    // Reset during PRESS_WAIT
    applyStimulus(1'b1, 3);
    #2 rst_n = 1'b0;
    #1 checkAllZero("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, D + 2);
    checkOutput("rst_wait_no_early", pressPulse, 1'b0);
    applyStimulus(1'b1, 1);
    checkOutput("rst_wait_redebounce", pressPulse, 1'b1);

    // Reset during PRESSED
    applyStimulus(1'b1, 3);
    checkOutput("rst_pressed_level_before", level, 1'b1);
    checkOutput("rst_pressed_run_before", runFlag, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("rst_pressed");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, D + 2);
    checkOutput("rst_pressed_no_early", pressPulse, 1'b0);
    applyStimulus(1'b1, 1);
    checkOutput("rst_pressed_redebounce", pressPulse, 1'b1);
    applyStimulus(1'b0, D + 8);

    // Randomized activity: mostly short glitches, some long holds, rare resets
    for (int seg = 0; seg < 200; seg++) begin
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(D + 2, 3 * L);
      else len = $urandom_range(1, D + 1);
      applyStimulus(v, len);
      if ($urandom_range(0, 29) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    applyStimulus(1'b0, D + 8);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
